// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA test-pattern source: mode encodings,
// index/counter widths and the colour-bar lookup.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_VBARS   = 2'b00,
        MODE_HBARS   = 2'b01,
        MODE_CHECKER = 2'b10,
        MODE_SOLID   = 2'b11
    } mode_e;

    localparam int COORD_W = 11;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 11;

    // Table order white, yellow, cyan, green, magenta, red, blue, black maps to
    // r = !idx[1], g = !idx[2], b = !idx[0]; result is right-aligned {r,g,b}.
    function automatic logic [23:0] bar_color(input logic [IDX_W-1:0] idx,
                                              input int r_bits,
                                              input int g_bits,
                                              input int b_bits);
        logic [23:0] r;
        logic [23:0] g;
        logic [23:0] b;
        r = idx[1] ? 24'd0 : ((24'd1 << r_bits) - 24'd1);
        g = idx[2] ? 24'd0 : ((24'd1 << g_bits) - 24'd1);
        b = idx[0] ? 24'd0 : ((24'd1 << b_bits) - 24'd1);
        return (r << (g_bits + b_bits)) | (g << b_bits) | b;
    endfunction

endpackage

// File: rtl/vga_bar_counter.sv
// Bar position tracker: counts LEN steps per bar and N bars per wrap.
// idx_next is the bar index that applies to the step being taken this cycle.
module vga_bar_counter
    import vga_pkg::*;
#(
    parameter int LEN = 80,
    parameter int N   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             adv,
    output logic [IDX_W-1:0] idx,
    output logic [IDX_W-1:0] idx_next
);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        if (load) begin
            idx_d = load_idx;
            cnt_d = load_cnt;
        end else if (adv) begin
            if (cnt_q == CNT_W'(LEN - 1)) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    assign idx      = idx_q;
    assign idx_next = idx_d;

endmodule

// File: rtl/vga_pattern_gen.sv
// Registered VGA test-pattern source (vertical/horizontal bars, checker, solid).
// Define VGA_PAT_SCROLL_EN to scroll the pattern horizontally once per frame.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int  R_BITS      = 3,
    parameter int  G_BITS      = 3,
    parameter int  B_BITS      = 2,
    parameter int  H_ACTIVE    = 640,
    parameter int  V_ACTIVE    = 480,
    parameter int  NUM_BARS    = 8,
    parameter int  CHECK_LOG2  = 5,
    parameter int  SCROLL_STEP = 1,
    localparam int COLOR_DEPTH = R_BITS + G_BITS + B_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [COLOR_DEPTH-1:0] solid_rgb,
    input  logic [COORD_W-1:0]     row,
    input  logic [COORD_W-1:0]     col,
    input  logic                   output_valid,
    input  logic                   frame_start,
    output logic [COLOR_DEPTH-1:0] rgb,
    output logic                   rgb_valid
);

    localparam int BAR_W = H_ACTIVE / NUM_BARS;
    localparam int BAR_H = V_ACTIVE / NUM_BARS;
    localparam int EXT_W = COORD_W + 1;

    generate
        if (NUM_BARS < 1 || NUM_BARS > 8) begin : g_bad_bars
            $error("NUM_BARS must be in 1..8");
        end
        if (H_ACTIVE % NUM_BARS != 0) begin : g_bad_h
            $error("H_ACTIVE must be a multiple of NUM_BARS");
        end
        if (V_ACTIVE % NUM_BARS != 0) begin : g_bad_v
            $error("V_ACTIVE must be a multiple of NUM_BARS");
        end
        if (SCROLL_STEP < 1 || SCROLL_STEP >= BAR_W) begin : g_bad_step
            $error("SCROLL_STEP must be in 1..BAR_W-1");
        end
    endgenerate

    mode_e                  mode_q;
    logic [COLOR_DEPTH-1:0] solid_q;
    logic [COLOR_DEPTH-1:0] rgb_q, rgb_d;
    logic                   rgb_valid_q;

    logic [COORD_W-1:0] offset;
    logic [IDX_W-1:0]   start_idx;
    logic [CNT_W-1:0]   start_cnt;

`ifdef VGA_PAT_SCROLL_EN
    logic [COORD_W-1:0] offset_q, offset_d;
    logic [IDX_W-1:0]   start_idx_q, start_idx_d;
    logic [CNT_W-1:0]   start_cnt_q, start_cnt_d;
    logic [EXT_W-1:0]   off_sum;
    logic [CNT_W:0]     cnt_sum;

    // Offset and the line-start counter phase advance together so the bar
    // counter starts each line exactly where ec = offset lands.
    always_comb begin
        off_sum     = {1'b0, offset_q} + EXT_W'(SCROLL_STEP);
        offset_d    = off_sum[COORD_W-1:0];
        if (off_sum >= EXT_W'(H_ACTIVE)) begin
            offset_d = COORD_W'(off_sum - EXT_W'(H_ACTIVE));
        end
        cnt_sum     = {1'b0, start_cnt_q} + (CNT_W + 1)'(SCROLL_STEP);
        start_cnt_d = cnt_sum[CNT_W-1:0];
        start_idx_d = start_idx_q;
        if (cnt_sum >= (CNT_W + 1)'(BAR_W)) begin
            start_cnt_d = CNT_W'(cnt_sum - (CNT_W + 1)'(BAR_W));
            start_idx_d = (start_idx_q == IDX_W'(NUM_BARS - 1)) ? '0 : start_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q    <= '0;
            start_idx_q <= '0;
            start_cnt_q <= '0;
        end else if (frame_start) begin
            offset_q    <= offset_d;
            start_idx_q <= start_idx_d;
            start_cnt_q <= start_cnt_d;
        end
    end

    assign offset    = offset_q;
    assign start_idx = start_idx_q;
    assign start_cnt = start_cnt_q;
`else
    assign offset    = '0;
    assign start_idx = '0;
    assign start_cnt = '0;
`endif

    logic [EXT_W-1:0]   ec_sum;
    logic [COORD_W-1:0] ec;

    always_comb begin
        ec_sum = {1'b0, col} + {1'b0, offset};
        ec     = ec_sum[COORD_W-1:0];
        if (ec_sum >= EXT_W'(H_ACTIVE)) begin
            ec = COORD_W'(ec_sum - EXT_W'(H_ACTIVE));
        end
    end

    logic             h_load, h_adv, v_load, v_adv;
    logic [IDX_W-1:0] h_idx, h_idx_next, v_idx, v_idx_next;

    assign h_load = output_valid && (col == '0);
    assign h_adv  = output_valid && !h_load;
    assign v_load = h_load && (row == '0);
    assign v_adv  = h_load && (row != '0);

    vga_bar_counter #(.LEN(BAR_W), .N(NUM_BARS)) u_hcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (h_load),
        .load_idx (start_idx),
        .load_cnt (start_cnt),
        .adv      (h_adv),
        .idx      (h_idx),
        .idx_next (h_idx_next)
    );

    vga_bar_counter #(.LEN(BAR_H), .N(NUM_BARS)) u_vcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (v_load),
        .load_idx ('0),
        .load_cnt ('0),
        .adv      (v_adv),
        .idx      (v_idx),
        .idx_next (v_idx_next)
    );

    // Registered indices are not needed here; the output stage uses idx_next.
    logic unused_idx;
    assign unused_idx = ^{h_idx, v_idx};

    logic in_active;
    logic chk_dark;

    assign in_active = (col < COORD_W'(H_ACTIVE)) && (row < COORD_W'(V_ACTIVE));
    assign chk_dark  = ec[CHECK_LOG2] ^ row[CHECK_LOG2];

    always_comb begin
        rgb_d = '0;
        if (output_valid && in_active) begin
            unique case (mode_q)
                MODE_VBARS:   rgb_d = COLOR_DEPTH'(bar_color(h_idx_next, R_BITS, G_BITS, B_BITS));
                MODE_HBARS:   rgb_d = COLOR_DEPTH'(bar_color(v_idx_next, R_BITS, G_BITS, B_BITS));
                MODE_CHECKER: rgb_d = chk_dark ? '0 : '1;
                MODE_SOLID:   rgb_d = solid_q;
            endcase
        end
    end

    // Mode/colour latch at frame boundary; the coincident pixel still sees the old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_VBARS;
            solid_q     <= '0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            if (frame_start) begin
                mode_q  <= mode_e'(mode);
                solid_q <= solid_rgb;
            end
            rgb_q       <= rgb_d;
            rgb_valid_q <= output_valid;
        end
    end

    assign rgb       = rgb_q;
    assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: randomized scan stimulus checked against
// an arithmetic reference model (division/modulo on coordinates).
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode;
    logic [7:0]  solid_rgb;
    logic [10:0] row;
    logic [10:0] col;
    logic        output_valid;
    logic        frame_start;
    logic [7:0]  rgb;
    logic        rgb_valid;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .solid_rgb    (solid_rgb),
        .row          (row),
        .col          (col),
        .output_valid (output_valid),
        .frame_start  (frame_start),
        .rgb          (rgb),
        .rgb_valid    (rgb_valid)
    );

`ifdef VGA_PAT_SCROLL_EN
    localparam int STEP = 1;
`else
    localparam int STEP = 0;
`endif

    localparam logic [7:0] TBL [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

    typedef struct packed {
        logic       v;
        logic [7:0] rgb;
        logic [10:0] r;
        logic [10:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_mode = 0;
    int   m_solid = 0;
    int   m_off = 0;

    function automatic logic [7:0] model_pix(input int md, input int sol, input int off,
                                             input int r, input int c);
        int ec;
        if (c >= 640 || r >= 480) return 8'h00;
        ec = (c + off) % 640;
        case (md)
            0:       return TBL[ec / 80];
            1:       return TBL[r / 60];
            2:       return ((((ec ^ r) >> 5) & 1) != 0) ? 8'h00 : 8'hFF;
            default: return 8'(sol);
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    task automatic drive(input int r, input int c, input bit v, input bit fs);
        exp_t e;
        @(negedge clk);
        row          = 11'(r);
        col          = 11'(c);
        output_valid = v;
        frame_start  = fs;
        e.v   = v;
        e.rgb = v ? model_pix(m_mode, m_solid, m_off, r, c) : 8'h00;
        e.r   = 11'(r);
        e.c   = 11'(c);
        exp_q.push_back(e);
        if (fs) begin
            m_mode  = int'(mode);
            m_solid = int'(solid_rgb);
            m_off   = (m_off + STEP) % 640;
        end
    endtask

    task automatic line(input int r, input int len);
        for (int c = 0; c < len; c++) drive(r, c, 1'b1, 1'b0);
        if ($urandom_range(3, 0) == 0) drive(r, 640 + int'($urandom_range(50, 0)), 1'b1, 1'b0);
        drive(r, 700, 1'b0, 1'b0);
    endtask

    task automatic fstrobe();
        drive(500, 0, 1'b0, 1'b1);
        drive(500, 1, 1'b0, 1'b0);
    endtask

    // Monitor: one expectation per driven cycle, compared after the capturing edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rgb !== e.rgb || rgb_valid !== e.v) begin
                errors++;
                $display("FAIL pixel r%0d c%0d: rgb=%02h valid=%0b, required rgb=%02h valid=%0b",
                         e.r, e.c, rgb, rgb_valid, e.rgb, e.v);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mode = 2'b00; solid_rgb = 8'h00; row = '0; col = '0;
        output_valid = 1'b0; frame_start = 1'b0;
        #12;
        check("reset_rgb", rgb, 8'h00);
        check("reset_rgb_valid", {7'b0, rgb_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Default vertical bars, full lines then short random ones
        line(0, 640);
        line(1, 640);
        line(2, 200);
        for (int r = 3; r < 10; r++) line(r, int'($urandom_range(100, 1)));

        // Horizontal bars over the whole frame plus rows below active
        mode = 2'b01;
        fstrobe();
        for (int r = 0; r < 482; r++) line(r, int'($urandom_range(4, 1)));

        // Checkerboard; mode/solid inputs change mid-frame without effect
        mode = 2'b10;
        fstrobe();
        for (int r = 0; r < 70; r++) begin
            if (r == 35) begin
                mode = 2'b11;
                solid_rgb = 8'h1C;
            end
            line(r, 70);
        end
        drive(70, 0, 1'b1, 1'b1);
        drive(70, 1, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) line(r, 20);

        // Random frames
        repeat (4) begin
            mode = 2'($urandom_range(3, 0));
            solid_rgb = 8'($urandom_range(255, 0));
            fstrobe();
            for (int r = 0; r < int'($urandom_range(130, 20)); r++)
                line(r, int'($urandom_range(110, 1)));
        end

        // Asynchronous reset mid-line during a solid frame
        mode = 2'b11;
        solid_rgb = 8'hE3;
        fstrobe();
        for (int c = 0; c < 11; c++) drive(0, c, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        output_valid = 1'b0;
        #1;
        check("async_rst_rgb", rgb, 8'h00);
        check("async_rst_rgb_valid", {7'b0, rgb_valid}, 8'h00);
        m_mode = 0; m_solid = 0; m_off = 0;
        repeat (2) @(posedge clk);
        #1;
        check("held_rst_rgb", rgb, 8'h00);
        check("held_rst_rgb_valid", {7'b0, rgb_valid}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        line(0, 100);
        line(1, 90);

        // Frame-boundary scroll behaviour (offset stays 0 without the scroll build)
        mode = 2'b00;
        fstrobe();
        line(0, 640);
        line(1, 640);
        repeat (79) begin
            fstrobe();
            line(0, 3);
        end
        line(0, 90);
        line(1, 5);

        drive(800, 800, 1'b0, 1'b0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
